// File: rtl/esc_pwm_gen.sv
// ESC PWM generator: fixed-period frames with a throttle-dependent pulse,
// a frame-qualified arming sequence, and an optional per-frame slew limit
// on the applied throttle (enabled by defining ESC_PWM_SLEW_EN).
module esc_pwm_gen #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned FRAME_US   = 2500,
  parameter int unsigned MIN_US     = 1000,
  parameter int unsigned ARM_FRAMES = 100,
  parameter int unsigned SLEW_STEP  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] cmd_in,
  input  logic       arm_in,
  output logic       pwm_out,
  output logic       armed,
  output logic       frame_strobe,
  output logic [7:0] applied_cmd
);

  localparam int unsigned DIV   = CLK_HZ / 1000000;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned US_W  = ($clog2(FRAME_US) > 12) ? $clog2(FRAME_US) : 12;
  localparam int unsigned CNT_W = $clog2(ARM_FRAMES + 1);

  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(DIV - 1);
  localparam logic [US_W-1:0]  US_MAX    = US_W'(FRAME_US - 1);
  localparam logic [US_W-1:0]  MIN_PULSE = US_W'(MIN_US);
  localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_FRAMES);

  typedef enum logic [1:0] {
    S_DISARMED,
    S_ARMING,
    S_ARMED
  } state_t;

  logic [PRE_W-1:0] r_pre;
  logic [US_W-1:0]  r_us;
  logic [US_W-1:0]  r_pulse;
  logic [CNT_W-1:0] r_arm_cnt;
  logic [7:0]       r_applied;
  logic             r_pwm;
  logic             r_strobe;
  state_t           r_state;

  logic             w_tick;
  logic             w_frame_start;
  logic [7:0]       w_slew;
  state_t           w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [7:0]       w_applied_nx;
  logic [US_W-1:0]  w_pulse_nx;
  logic [US_W-1:0]  w_pulse_cur;

  assign w_tick        = (r_pre == PRE_MAX);
  assign w_frame_start = (r_pre == '0) && (r_us == '0);
  assign w_cnt_inc     = r_arm_cnt + CNT_W'(1);

  // Prescaler produces the 1 us tick; the us counter spans one frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre <= '0;
      r_us  <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
      r_us  <= (r_us == US_MAX) ? '0 : r_us + US_W'(1);
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

`ifdef ESC_PWM_SLEW_EN
  localparam logic [7:0] STEP = (SLEW_STEP > 255) ? 8'hFF : 8'(SLEW_STEP);

  // Step the applied throttle toward the command by at most STEP per frame.
  always_comb begin
    w_slew = r_applied;
    if (cmd_in > r_applied)
      w_slew = ((cmd_in - r_applied) > STEP) ? r_applied + STEP : cmd_in;
    else if (cmd_in < r_applied)
      w_slew = ((r_applied - cmd_in) > STEP) ? r_applied - STEP : cmd_in;
  end
`else
  assign w_slew = cmd_in;
`endif

  // Arming FSM; only frame start moves it, except an arm drop while armed.
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_arm_cnt;
    w_applied_nx = '0;
    case (r_state)
      S_DISARMED: begin
        if (w_frame_start && arm_in && (cmd_in == '0)) begin
          w_state_nx = S_ARMING;
          w_cnt_nx   = '0;
        end
      end
      S_ARMING: begin
        if (w_frame_start) begin
          if (arm_in && (cmd_in == '0)) begin
            if (w_cnt_inc == ARM_LAST) begin
              w_state_nx = S_ARMED;
              w_cnt_nx   = '0;
            end else begin
              w_cnt_nx = w_cnt_inc;
            end
          end else begin
            w_state_nx = S_DISARMED;
            w_cnt_nx   = '0;
          end
        end
      end
      S_ARMED: begin
        w_applied_nx = r_applied;
        if (!arm_in) begin
          w_state_nx   = S_DISARMED;
          w_applied_nx = '0;
        end else if (w_frame_start) begin
          w_applied_nx = w_slew;
        end
      end
      default: begin
        w_state_nx = S_DISARMED;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // The pulse for a frame is taken from the throttle applied at its start,
  // so the first clk of the frame already compares against the new width.
  assign w_pulse_nx  = MIN_PULSE + {{(US_W-10){1'b0}}, w_applied_nx, 2'b00};
  assign w_pulse_cur = w_frame_start ? w_pulse_nx : r_pulse;

  // FSM state, latched pulse width and the registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_DISARMED;
      r_arm_cnt <= '0;
      r_applied <= '0;
      r_pulse   <= '0;
      r_pwm     <= 1'b0;
      r_strobe  <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_arm_cnt <= w_cnt_nx;
      r_applied <= w_applied_nx;
      r_pulse   <= w_pulse_cur;
      r_pwm     <= (r_us < w_pulse_cur);
      r_strobe  <= w_frame_start;
    end
  end

  assign pwm_out      = r_pwm;
  assign frame_strobe = r_strobe;
  assign armed        = (r_state == S_ARMED);
  assign applied_cmd  = r_applied;

endmodule

// File: tb/tb_esc_pwm_gen.sv
// Randomized bench for esc_pwm_gen with a frame-level reference model.
module tb_esc_pwm_gen;

  localparam int DIV       = 2;
  localparam int FRAME_US  = 2500;
  localparam int MIN_US    = 1000;
  localparam int ARM_FR    = 3;
  localparam int STEP      = 4;
  localparam int FRAME_CLK = DIV * FRAME_US;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] cmd_in = '0;
  logic       arm_in = 1'b0;
  logic       pwm_out;
  logic       armed;
  logic       frame_strobe;
  logic [7:0] applied_cmd;

  int n_total = 0;
  int n_pass  = 0;

  esc_pwm_gen #(
    .CLK_HZ    (2000000),
    .FRAME_US  (2500),
    .MIN_US    (1000),
    .ARM_FRAMES(3),
    .SLEW_STEP (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_in      (cmd_in),
    .arm_in      (arm_in),
    .pwm_out     (pwm_out),
    .armed       (armed),
    .frame_strobe(frame_strobe),
    .applied_cmd (applied_cmd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  // Reference model: position in frame in clks, state 0/1/2 = disarmed/arming/armed.
  int m_pos = 0, m_state = 0, m_cnt = 0, m_app = 0, m_pulse_clk = 0;
  bit e_pwm = 0, e_strobe = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pos = 0; m_state = 0; m_cnt = 0; m_app = 0; m_pulse_clk = 0;
      e_pwm = 0; e_strobe = 0;
    end else begin
      bit fs;
      int diff;
      fs = (m_pos == 0);
      if (m_state == 2 && !arm_in) begin
        m_state = 0; m_app = 0;
      end else if (fs) begin
        if (m_state == 0) begin
          if (arm_in && cmd_in == 0) begin m_state = 1; m_cnt = 0; end
        end else if (m_state == 1) begin
          if (arm_in && cmd_in == 0) begin
            m_cnt++;
            if (m_cnt == ARM_FR) m_state = 2;
          end else begin
            m_state = 0; m_cnt = 0;
          end
        end else begin
`ifdef ESC_PWM_SLEW_EN
          diff = int'(cmd_in) - m_app;
          if (diff > STEP) m_app += STEP;
          else if (diff < -STEP) m_app -= STEP;
          else m_app = cmd_in;
`else
          diff = 0;
          m_app = cmd_in;
`endif
        end
      end
      if (fs) m_pulse_clk = (MIN_US + 4 * m_app) * DIV;
      e_strobe = fs;
      e_pwm = (m_pos < m_pulse_clk);
      m_pos = (m_pos + 1) % FRAME_CLK;
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (reset_n)
      chk("cycle{pwm,strobe,armed,applied}",
          int'({pwm_out, frame_strobe, armed, applied_cmd}),
          int'({e_pwm, e_strobe, (m_state == 2), 8'(m_app)}));
  end

  // Pulse width and strobe period of the frame that just ended.
  int cur_w = 0, since = 0, last_width = 0, last_period = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      cur_w = 0; since = 0;
    end else if (frame_strobe) begin
      last_width = cur_w; last_period = since;
      cur_w = pwm_out ? 1 : 0; since = 1;
    end else begin
      cur_w += pwm_out ? 1 : 0; since++;
    end
  end

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!frame_strobe && n < FRAME_CLK + 1000);
    if (!frame_strobe) chk("strobe_timeout", 0, 1);
  endtask

  // Runs to the next frame strobe; cmd_in optionally wanders mid-frame and
  // settles at final_cmd before the frame boundary.
  task automatic run_frame(input logic [7:0] final_cmd, input bit wig);
    int n;
    for (int i = 0; i < FRAME_CLK - 200; i++) begin
      @(posedge clk); #2;
      if (wig) cmd_in = 8'($urandom);
    end
    cmd_in = final_cmd;
    wait_strobe(n);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

`ifdef ESC_PWM_SLEW_EN
  localparam int A1 = 4, A2 = 8, A3 = 10, A4 = 14;
  localparam int P1 = 2032, P2 = 2064, P3 = 2080, P4 = 2112;
`else
  localparam int A1 = 10, A2 = 10, A3 = 10, A4 = 255;
  localparam int P1 = 2080, P2 = 2080, P3 = 2080, P4 = 4040;
`endif

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pwm", pwm_out, 0);
    chk("reset_armed", armed, 0);
    chk("reset_strobe", frame_strobe, 0);
    chk("reset_applied", applied_cmd, 0);
    @(negedge clk); #1 reset_n = 1'b1;
    wait_strobe(n);
    chk("first_strobe_delay", n, 1);

    // Disarmed frame with random throttle noise.
    run_frame(8'd0, 1'b1);
    chk("disarmed_width", last_width, 2000);
    chk("frame_period", last_period, 5000);
    chk("disarmed_armed", armed, 0);

    // Arming aborted by a non-zero command at the second frame start.
    arm_in = 1'b1;
    run_frame(8'd0, 1'b1);
    run_frame(8'd10, 1'b1);
    chk("abort_armed", armed, 0);
    run_frame(8'd10, 1'b1);
    chk("abort_stays_disarmed", armed, 0);

    // Full arming: four frame starts with cmd 0.
    run_frame(8'd0, 1'b1);
    run_frame(8'd0, 1'b1);
    run_frame(8'd0, 1'b1);
    chk("arming_3rd_armed", armed, 0);
    run_frame(8'd0, 1'b1);
    chk("armed_at_4th", armed, 1);
    chk("armed_applied0", applied_cmd, 0);

    // Throttle step 0 -> 10, then 255.
    run_frame(8'd10, 1'b1);
    chk("applied_f1", applied_cmd, A1);
    chk("width_armed0", last_width, 2000);
    run_frame(8'd10, 1'b1);
    chk("applied_f2", applied_cmd, A2);
    chk("width_f1", last_width, P1);
    run_frame(8'd10, 1'b1);
    chk("applied_f3", applied_cmd, A3);
    chk("width_f2", last_width, P2);
    run_frame(8'd255, 1'b1);
    chk("applied_f4", applied_cmd, A4);
    chk("width_f3", last_width, P3);

    // Arm dropped mid-pulse.
    repeat (500) @(posedge clk);
    #2 arm_in = 1'b0;
    @(negedge clk); #1;
    chk("drop_before_edge_armed", armed, 1);
    @(negedge clk); #1;
    chk("drop_armed", armed, 0);
    chk("drop_applied", applied_cmd, 0);
    chk("drop_pwm_continues", pwm_out, 1);
    wait_strobe(n);
    chk("drop_width_full", last_width, P4);
    run_frame(8'd0, 1'b1);
    chk("after_drop_width", last_width, 2000);

    // Asynchronous reset mid-pulse.
    repeat (300) @(posedge clk);
    #2;
    chk("pre_reset_pwm", pwm_out, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_reset_pwm", pwm_out, 0);
    chk("async_reset_applied", applied_cmd, 0);
    @(negedge clk); #1 reset_n = 1'b1;
    wait_strobe(n);
    chk("first_strobe_after_reset", n, 1);

    // Random arm/cmd traffic for one frame, checked by the model.
    for (int i = 0; i < FRAME_CLK + 100; i++) begin
      @(posedge clk); #2;
      arm_in = ($urandom_range(0, 7) != 0);
      cmd_in = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/esc_pwm_gen.md
ESC_PWM_GEN -- requirements
Module: esc_pwm_gen

Interface
REQ-001 Parameter CLK_HZ, default 50000000, clk frequency in Hz (integer multiple of 1000000) SHALL be supported.
REQ-002 Parameter FRAME_US, default 2500, PWM frame period in microseconds SHALL be supported.
REQ-003 Parameter MIN_US, default 1000, pulse width in microseconds at zero throttle SHALL be supported.
REQ-004 Parameter ARM_FRAMES, default 100, consecutive qualifying frames required to arm SHALL be supported.
REQ-005 Parameter SLEW_STEP, default 4, maximum change of applied throttle per frame SHALL be supported.
REQ-006 Port clk  input  1  system clock, all logic rising-edge.
REQ-007 Port reset_n  input  1  asynchronous, active-low reset.
REQ-008 Port cmd_in  input  8  throttle command 0..255, from the HPS-written PIO output byte, same clock domain.
REQ-009 Port arm_in  input  1  arm request, level.
REQ-010 Port pwm_out  output  1  ESC pulse, registered.
REQ-011 Port armed  output  1  high only in state ARMED.
REQ-012 Port frame_strobe  output  1  one-clk pulse at each frame start.
REQ-013 Port applied_cmd  output  8  throttle value used for the current frame.

Function
REQ-014 A prescaler SHALL count 0..CLK_HZ/1000000-1 and produce a 1 us tick when it wraps; a us counter SHALL count 0..FRAME_US-1, advancing on the tick, wrapping to 0.
REQ-015 Frame start SHALL be the clk where prescaler==0 and us counter==0; frame_strobe SHALL be high for exactly that clk.
REQ-016 At frame start the block SHALL latch pulse_us = MIN_US + 4*applied_cmd (next value, range MIN_US..MIN_US+1020, 12-bit unsigned, no overflow).
REQ-017 pwm_out SHALL be high while us counter < latched pulse_us, registered one clk after the counters; pulse width is exact to the clk.
REQ-018 States: DISARMED, ARMING, ARMED; only frame start evaluates transitions except REQ-021.
REQ-019 DISARMED -> ARMING at frame start when arm_in==1 and cmd_in==0; arm frame counter cleared.
REQ-020 ARMING: at each frame start with arm_in==1 and cmd_in==0 counter increments; on reaching ARM_FRAMES -> ARMED; any frame start with arm_in==0 or cmd_in!=0 -> DISARMED, counter cleared.
REQ-021 ARMED: arm_in==0 on any clk SHALL go DISARMED next clk, armed low and applied_cmd 0 next clk; the pulse already latched for the current frame completes unchanged.
REQ-022 applied_cmd SHALL be 0 in DISARMED and ARMING, giving MIN_US pulses every frame.
REQ-023 In ARMED, applied_cmd SHALL update only at frame start per REQ-029/REQ-030.
REQ-024 cmd_in changes mid-frame SHALL have no effect until the next frame start.

Reset
REQ-025 On reset_n low: pwm_out 0, armed 0, frame_strobe 0, applied_cmd 0, state DISARMED, prescaler, us counter, arm counter, latched pulse all 0.
REQ-026 First frame_strobe SHALL occur on the first clk edge after reset_n deasserts.
REQ-027 Reset mid-pulse SHALL drive pwm_out low immediately (asynchronous).

Configuration
REQ-028 Macro ESC_PWM_SLEW_EN selects slew limiting.
REQ-029 Defined: at frame start in ARMED, applied_cmd moves toward cmd_in by min(|cmd_in-applied_cmd|, SLEW_STEP), saturating at 0 and 255.
REQ-030 Undefined: at frame start in ARMED, applied_cmd = cmd_in.

Verification (CLK_HZ=2000000, FRAME_US=2500, ARM_FRAMES=3, SLEW_STEP=4, ESC_PWM_SLEW_EN defined)
REQ-031 Reset release, arm_in=0 -> frame_strobe every 5000 clk, pwm_out high 2000 clk per frame, armed 0.
REQ-032 arm_in=1, cmd_in=0 -> armed rises one clk after the 4th frame start (DISARMED frame plus 3 ARMING frames).
REQ-033 ARMING with cmd_in=10 at second frame start -> back to DISARMED, armed never rises.
REQ-034 ARMED, cmd_in 0->10 -> applied_cmd 4, 8, 10 on successive frames; pulses 2032, 2064, 2080 clk.
REQ-035 ARMED, cmd_in=255 steady, arm_in dropped mid-pulse -> armed low next clk, current pulse full width, next frame 2000 clk.
REQ-036 Without ESC_PWM_SLEW_EN, ARMED, cmd_in=255 -> next frame applied_cmd 255, pulse 4040 clk.
